// File: rtl/spi_feed_pkg.sv
// Shared types and default constants for the SPI transmit feeder.
// Imported by the feeder top, its FIFO and the bench.
package spi_feed_pkg;

    localparam int unsigned SPI_DW     = 8;
    localparam int unsigned FEED_DEPTH = 8;
    localparam int unsigned FEED_GAP   = 2;
    localparam int unsigned FEED_TMO   = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_XFER,
        ST_GAP
    } feed_state_t;

    // Width of a counter that must hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_tx_feeder_if.sv
// Host-write and SPI-master-launch signals of the feeder, bundled as one interface.
// slave is the feeder's view; master is the view of whatever drives host writes and cs.
interface spi_tx_feeder_if #(
    parameter int unsigned DEPTH = spi_feed_pkg::FEED_DEPTH
);

    // Host side
    logic                            wr_en;
    logic [spi_feed_pkg::SPI_DW-1:0] wr_data;
    logic                            full;
    logic                            empty;
    logic [$clog2(DEPTH):0]          count;

    // SPI master side
    logic                            newd;
    logic [spi_feed_pkg::SPI_DW-1:0] din;
    logic                            cs;

    // Status
    logic                            busy;
    logic                            ovf;
    logic                            tmo_err;

    modport slave (
        input  wr_en,
        input  wr_data,
        input  cs,
        output full,
        output empty,
        output count,
        output newd,
        output din,
        output busy,
        output ovf,
        output tmo_err
    );

    modport master (
        output wr_en,
        output wr_data,
        output cs,
        input  full,
        input  empty,
        input  count,
        input  newd,
        input  din,
        input  busy,
        input  ovf,
        input  tmo_err
    );

endinterface

// File: rtl/spi_tx_feeder_sync_fifo.sv
// Synchronous FIFO with registered full/empty/count and a registered read port.
// rd_data updates only on an accepted read and otherwise holds the last popped entry.
module sync_fifo
    import spi_feed_pkg::*;
#(
    parameter int unsigned DEPTH = FEED_DEPTH,
    parameter int unsigned DW    = SPI_DW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [DW-1:0]          wr_data,
    input  logic                   rd_en,
    output logic [DW-1:0]          rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic [DW-1:0] rd_data_q, rd_data_d;

    logic wr_ok;
    logic rd_ok;

    // A write against a full FIFO is dropped even if a read frees a slot in the same cycle.
    assign wr_ok = wr_en & ~full_q;
    assign rd_ok = rd_en & ~empty_q;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rd_data_d = rd_data_q;

        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_ok) begin
            rd_ptr_d  = rd_ptr_q + AW'(1);
            rd_data_d = mem_q[rd_ptr_q];
        end

        unique case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        full_d  = (count_d == CNT_FULL);
        empty_d = (count_d == '0);
    end

    // NOTE: storage carries no reset; count/empty gate every read, so stale entries are never seen.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
    assign full    = full_q;
    assign empty   = empty_q;
    assign count   = count_q;

endmodule

// File: rtl/spi_tx_feeder.sv
// Byte queue and launch sequencer upstream of the SPI daisy-chain master.
// Raises newd once per queued byte, waits out the transfer and an idle gap, and guards the launch with a watchdog.
module spi_tx_feeder
    import spi_feed_pkg::*;
#(
    parameter int unsigned DEPTH = FEED_DEPTH,
    parameter int unsigned GAP   = FEED_GAP,
    parameter int unsigned TMO   = FEED_TMO
) (
    input  logic           clk,
    input  logic           rst_n,
    spi_tx_feeder_if.slave bus
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned GW = cnt_width(GAP + 1);
    localparam int unsigned WW = cnt_width(TMO);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP);
    localparam logic [WW-1:0] WDOG_LAST = WW'(TMO - 1);

    feed_state_t   state_q, state_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic          newd_q, newd_d;
    logic          busy_q, busy_d;
    logic          ovf_q, ovf_d;
    logic          tmo_err_q, tmo_err_d;

    logic              pop;
    logic              tmo_hit;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [SPI_DW-1:0] fifo_rd_data;

    sync_fifo #(
        .DEPTH (DEPTH),
        .DW    (SPI_DW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (bus.wr_en),
        .wr_data (bus.wr_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            gap_q     <= '0;
            wdog_q    <= '0;
            newd_q    <= 1'b0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
            tmo_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            wdog_q    <= wdog_d;
            newd_q    <= newd_d;
            busy_q    <= busy_d;
            ovf_q     <= ovf_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        wdog_d  = wdog_q;
        pop     = 1'b0;
        tmo_hit = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // The pop registers the head byte into din on the same edge that raises newd.
                if (!fifo_empty && bus.cs) begin
                    pop     = 1'b1;
                    wdog_d  = '0;
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                // cs falling wins over a watchdog expiring on the same edge.
                if (!bus.cs) begin
                    state_d = ST_XFER;
                end else if (wdog_q == WDOG_LAST) begin
                    tmo_hit = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wdog_d = wdog_q + WW'(1);
                end
            end
            ST_XFER: begin
                if (bus.cs) begin
                    if (GAP == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        gap_d   = '0;
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they leave flops aligned with the state itself.
    always_comb begin
        newd_d    = (state_d == ST_LAUNCH);
        busy_d    = (state_d != ST_IDLE);
        ovf_d     = ovf_q | (bus.wr_en & fifo_full);
        tmo_err_d = tmo_err_q | tmo_hit;
    end

    assign bus.full    = fifo_full;
    assign bus.empty   = fifo_empty;
    assign bus.count   = fifo_count;
    assign bus.din     = fifo_rd_data;
    assign bus.newd    = newd_q;
    assign bus.busy    = busy_q;
    assign bus.ovf     = ovf_q;
    assign bus.tmo_err = tmo_err_q;

endmodule

// File: tb/tb_spi_tx_feeder.sv
// Directed bench for spi_tx_feeder: emulates the SPI master on newd/din/cs and checks every cycle
// against a timestamp-based model of the queue, launch, gap and watchdog rules.
module tb_spi_tx_feeder;
    import spi_feed_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned GAP   = 2;
    localparam int unsigned TMO   = 64;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_errors = 0;

    spi_tx_feeder_if #(.DEPTH(DEPTH)) bus ();

    spi_tx_feeder #(
        .DEPTH (DEPTH),
        .GAP   (GAP),
        .TMO   (TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: a byte queue plus edge timestamps for launch and release.
    // ------------------------------------------------------------------
    logic [7:0] m_fifo[$];
    logic [7:0] m_din = '0;
    bit         m_newd;
    bit         m_busy;
    bit         m_ovf;
    bit         m_tmo;
    bit         m_was_full;
    int         m_cyc     = 0;
    int         m_launch  = 0;
    int         m_release = -1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_fifo.delete();
            m_din     = '0;
            m_newd    = 1'b0;
            m_busy    = 1'b0;
            m_ovf     = 1'b0;
            m_tmo     = 1'b0;
            m_release = -1;
        end else begin
            m_cyc++;
            m_was_full = (m_fifo.size() == DEPTH);
            if (!m_busy) begin
                if (bus.cs && m_fifo.size() > 0) begin
                    m_din     = m_fifo.pop_front();
                    m_newd    = 1'b1;
                    m_busy    = 1'b1;
                    m_launch  = m_cyc;
                    m_release = -1;
                end
            end else if (m_newd) begin
                if (!bus.cs) begin
                    m_newd = 1'b0;
                end else if (m_cyc - m_launch == TMO) begin
                    m_newd = 1'b0;
                    m_busy = 1'b0;
                    m_tmo  = 1'b1;
                end
            end else if (m_release < 0) begin
                if (bus.cs) begin
                    if (GAP == 0) m_busy = 1'b0;
                    else m_release = m_cyc + GAP + 1;
                end
            end else if (m_cyc == m_release) begin
                m_busy = 1'b0;
            end
            if (bus.wr_en) begin
                if (m_was_full) m_ovf = 1'b1;
                else m_fifo.push_back(bus.wr_data);
            end
        end
    end

    always @(negedge clk) begin
        check("cmp_newd",    bus.newd,    m_newd);
        check("cmp_din",     bus.din,     m_din);
        check("cmp_busy",    bus.busy,    m_busy);
        check("cmp_ovf",     bus.ovf,     m_ovf);
        check("cmp_tmo_err", bus.tmo_err, m_tmo);
        check("cmp_count",   bus.count,   m_fifo.size());
        check("cmp_full",    bus.full,    m_fifo.size() == DEPTH);
        check("cmp_empty",   bus.empty,   m_fifo.size() == 0);
    end

    // ------------------------------------------------------------------
    // SPI master emulation: wait for newd, take the byte, run a short transfer.
    // Returns at the negedge after the edge that samples cs high again.
    // ------------------------------------------------------------------
    task automatic serve(input logic [7:0] exp_byte, input int exp_wait, input string tag);
        int n;
        n = 0;
        while (bus.newd !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_launch_wait"}, n, exp_wait);
        check({tag, "_din"}, bus.din, exp_byte);
        bus.cs = 1'b0;
        @(negedge clk);
        check({tag, "_newd_drop"}, bus.newd, 1'b0);
        repeat (3) @(negedge clk);
        bus.cs = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_full"},    bus.full,    1'b0);
        check({tag, "_empty"},   bus.empty,   1'b1);
        check({tag, "_count"},   bus.count,   0);
        check({tag, "_newd"},    bus.newd,    1'b0);
        check({tag, "_din"},     bus.din,     8'h00);
        check({tag, "_busy"},    bus.busy,    1'b0);
        check({tag, "_ovf"},     bus.ovf,     1'b0);
        check({tag, "_tmo_err"}, bus.tmo_err, 1'b0);
    endtask

    logic [7:0] burst [3] = '{8'h11, 8'h22, 8'h33};
    logic [7:0] tail  [3] = '{8'hC1, 8'hC2, 8'hC3};

    initial begin
        int hi;
        rst_n       = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.cs      = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_values("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Single byte: newd one clock after the write, busy through the gap.
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'hA7;
        @(negedge clk);
        bus.wr_en = 1'b0;
        check("t1_empty", bus.empty, 1'b0);
        check("t1_count", bus.count, 1);
        check("t1_newd_pre", bus.newd, 1'b0);
        serve(8'hA7, 1, "t1");
        check("t1_busy_m", bus.busy, 1'b1);
        repeat (GAP) begin
            @(negedge clk);
            check("t1_busy_gap", bus.busy, 1'b1);
        end
        @(negedge clk);
        check("t1_busy_clr", bus.busy, 1'b0);

        // Burst of three queued while the master holds cs low.
        bus.cs = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = burst[i];
            @(negedge clk);
        end
        bus.wr_en = 1'b0;
        check("t2_count3", bus.count, 3);
        bus.cs = 1'b1;
        serve(burst[0], 1, "t2a");
        check("t2_count2", bus.count, 2);
        serve(burst[1], GAP + 2, "t2b");
        check("t2_count1", bus.count, 1);
        serve(burst[2], GAP + 2, "t2c");
        check("t2_count0", bus.count, 0);
        repeat (GAP + 1) @(negedge clk);
        check("t2_idle", bus.busy, 1'b0);

        // Overflow: DEPTH+2 writes with no pops possible.
        bus.cs = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'h80 | 8'(i);
            @(negedge clk);
        end
        bus.wr_en = 1'b0;
        check("t3_full", bus.full, 1'b1);
        check("t3_count", bus.count, DEPTH);
        check("t3_ovf", bus.ovf, 1'b1);

        // Full FIFO with a write on the pop cycle: write dropped, one entry leaves.
        bus.cs      = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'hEE;
        @(negedge clk);
        bus.wr_en = 1'b0;
        check("t4_count", bus.count, DEPTH - 1);
        check("t4_full", bus.full, 1'b0);
        check("t4_newd", bus.newd, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            serve(8'h80 | 8'(i), (i == 0) ? 0 : GAP + 2, "t4");
        end
        repeat (GAP + 1) @(negedge clk);
        check("t4_drained", bus.empty, 1'b1);
        check("t4_no_extra", bus.busy, 1'b0);
        check("t4_tmo_clear", bus.tmo_err, 1'b0);

        // Watchdog: cs never falls for the first byte; the second launches afterwards.
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h5A;
        @(negedge clk);
        bus.wr_data = 8'h6B;
        @(negedge clk);
        bus.wr_en = 1'b0;
        check("t5_newd", bus.newd, 1'b1);
        check("t5_din", bus.din, 8'h5A);
        hi = 0;
        while (bus.newd === 1'b1 && hi < TMO + 8) begin
            hi++;
            @(negedge clk);
        end
        check("t5_newd_high_clocks", hi, TMO);
        check("t5_tmo_err", bus.tmo_err, 1'b1);
        check("t5_busy", bus.busy, 1'b0);
        check("t5_count", bus.count, 1);
        serve(8'h6B, 1, "t5b");
        repeat (GAP + 1) @(negedge clk);

        // Asynchronous reset in the middle of a transfer with two bytes queued.
        for (int i = 0; i < 3; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = tail[i];
            @(negedge clk);
        end
        bus.wr_en = 1'b0;
        check("t6_newd", bus.newd, 1'b1);
        bus.cs = 1'b0;
        @(negedge clk);
        check("t6_xfer_busy", bus.busy, 1'b1);
        check("t6_xfer_count", bus.count, 2);
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("t6_async");
        bus.cs = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_empty_after", bus.empty, 1'b1);
        check("t6_newd_after", bus.newd, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule
